mem_mgr_noc_out_arbiter: RTL and testbench
==========================================

// Module: mem_mgr_noc_out_arbiter
// PURPOSE
//  Packet-level arbiter sharing the single 32-bit NoC output stream of a DRAM tile among N_SRC
//  response sources (memory-manager encoder, mailbox/queue responder, error reporter, ...).
//  Sits between the per-source NoC encoders and the tile router port. Grants one source
//  at a time round-robin, holds the grant until that packet's TLAST is transferred, and
//  registers the output through a one-entry buffer so router backpressure is timing-isolated.
// PARAMETERS
//  N_SRC     4   number of requesting sources (2..8)
//  SRC_IDX_W 2   width of grant index, must equal $clog2(N_SRC)
// PORTS
//  clk_ctrl           in   1          control clock; all logic on posedge
//  clk_ctrl_rst_high  in   1          asynchronous reset, active-high
//  src_TVALID         in   N_SRC      per-source beat valid
//  src_TDATA          in   N_SRC*32   per-source beat data, source i at [32*i+31:32*i]
//  src_TKEEP          in   N_SRC*4    per-source byte keep, source i at [4*i+3:4*i]
//  src_TLAST          in   N_SRC      per-source last beat of packet
//  src_TREADY         out  N_SRC      per-source beat accepted (one-hot or zero)
//  stream_out_TVALID  out  1          registered beat valid toward router
//  stream_out_TDATA   out  32         registered beat data
//  stream_out_TKEEP   out  4          registered byte keep
//  stream_out_TLAST   out  1          registered last beat
//  stream_out_TREADY  in   1          router accepts beat
//  arb_busy           out  1          1 while a multi-beat packet holds the grant
//  arb_grant          out  SRC_IDX_W  index of current/last granted source
// BEHAVIOUR
//  Reset: all stream_out_* = 0, src_TREADY = 0, arb_busy = 0, arb_grant = 0, rr_ptr = 0,
//   state = ARB_IDLE, output buffer empty. Reset mid-packet abandons the packet; no beats
//   of it are emitted after reset release; sources must restart from their header.
//  Output buffer: can_take = !stream_out_TVALID | stream_out_TREADY. Accepted beat appears on
//   stream_out_* the cycle after acceptance (latency 1). stream_out_* hold stable while
//   TVALID=1 & TREADY=0. TVALID drops to 0 when TREADY=1 and no new beat accepted.
//  Accept: beat from source g when src_TVALID[g] & src_TREADY[g]; src_TREADY[g] =
//   can_take & (source g selected); at most one src_TREADY bit set per cycle.
//  FSM ARB_IDLE: if can_take & |src_TVALID: select g = first valid index searching from
//   rr_ptr upward, wrapping N_SRC-1 -> 0; accept its beat this cycle; arb_grant <= g.
//   If that beat has TLAST=1 (single-beat packet): stay ARB_IDLE, rr_ptr <= g+1 (mod N_SRC).
//   Else -> ARB_LOCK, arb_busy <= 1. No valid or !can_take: stay, nothing accepted.
//  FSM ARB_LOCK: only source arb_grant may be accepted; other sources see TREADY=0 even
//   if valid. Granted source TVALID=0 (bubble) -> wait, no timeout. On accepted beat with
//   TLAST=1 -> ARB_IDLE, arb_busy <= 0, rr_ptr <= arb_grant+1 (mod N_SRC).
//  Fairness: every valid source granted within N_SRC packets. rr_ptr wrap uses mod N_SRC
//   arithmetic (not power-of-two wrap) for non-power-of-two N_SRC.
//  Simultaneous: output drain and new accept in same cycle -> buffer reloaded, TVALID stays 1.
//  TDATA/TKEEP passed unmodified; arbiter never inspects headers nor inserts beats.
// CONFIGURATION
//  MGR_ARB_SRC0_PRIO_EN defined: in ARB_IDLE source 0 wins whenever src_TVALID[0]=1,
//   regardless of rr_ptr; rr_ptr not advanced by source-0 grants; remaining sources
//   round-robin as above. Lock-until-TLAST unchanged (source 0 never preempts a packet).
//  Not defined: pure round-robin over all N_SRC sources, source 0 has no precedence.
// TESTING
//  1. Reset, src0 sends 3-beat pkt 0x1A00_0001/0xDEAD_BEEF/0x0000_0042, TREADY=1 -> same
//     3 beats out, 1 cycle later each, TLAST on 3rd only, arb_grant=0, arb_busy 1 then 0.
//  2. src0..src3 all hold 1-beat pkts (data=0x100+i) continuously -> output order
//     0x100,0x101,0x102,0x103,0x100..., one beat per cycle, no bubbles.
//  3. src1 mid 4-beat pkt, src2 asserts valid -> src2 TREADY=0 until src1 TLAST
//     accepted; src2 beat appears next; src1 bubble of 5 cycles leaves grant held.
//  4. TREADY toggles 1,0,0,1 during 4-beat pkt -> no beat lost/duplicated, stream_out_*
//     stable across stalls, all src_TREADY=0 while buffer full and stalled.
//  5. clk_ctrl_rst_high pulsed after beat 2 of 4-beat src3 pkt -> outputs 0 next edge,
//     arb_grant=0; new src2 pkt afterwards emitted intact.
//  6. MGR_ARB_SRC0_PRIO_EN: src0 and src1 both valid with rr_ptr=1 -> src0 granted first;
//     without macro -> src1 granted first.

Source files
------------

// File: rtl/mem_mgr_noc_out_arbiter.sv
// Round-robin packet arbiter merging N_SRC response streams onto one registered 32-bit NoC output.
// Optional feature macro MGR_ARB_SRC0_PRIO_EN: source 0 wins idle arbitration whenever it is valid.
module mem_mgr_noc_out_arbiter #(
  parameter int N_SRC     = 4,
  parameter int SRC_IDX_W = 2
) (
  input  logic                   clk_ctrl,
  input  logic                   clk_ctrl_rst_high,
  input  logic [N_SRC-1:0]       src_TVALID,
  input  logic [N_SRC*32-1:0]    src_TDATA,
  input  logic [N_SRC*4-1:0]     src_TKEEP,
  input  logic [N_SRC-1:0]       src_TLAST,
  output logic [N_SRC-1:0]       src_TREADY,
  output logic                   stream_out_TVALID,
  output logic [31:0]            stream_out_TDATA,
  output logic [3:0]             stream_out_TKEEP,
  output logic                   stream_out_TLAST,
  input  logic                   stream_out_TREADY,
  output logic                   arb_busy,
  output logic [SRC_IDX_W-1:0]   arb_grant
);

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_e;

  arb_state_e             state_q, state_d;
  logic [SRC_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_IDX_W-1:0]   grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic                   out_valid_q, out_valid_d;
  logic [31:0]            out_data_q, out_data_d;
  logic [3:0]             out_keep_q, out_keep_d;
  logic                   out_last_q, out_last_d;

  logic [SRC_IDX_W-1:0]   sel_idx;
  logic                   sel_found;
  logic [SRC_IDX_W:0]     cand;
  logic [SRC_IDX_W-1:0]   acc_idx;
  logic [N_SRC-1:0]       ready;
  logic                   can_take;
  logic                   accept;

  // Modulo-N_SRC increment so non-power-of-two source counts wrap correctly.
  function automatic logic [SRC_IDX_W-1:0] next_idx(input logic [SRC_IDX_W-1:0] idx);
    if (idx == SRC_IDX_W'(N_SRC - 1)) begin
      return '0;
    end
    return idx + SRC_IDX_W'(1);
  endfunction

  function automatic logic [SRC_IDX_W-1:0] adv_ptr(input logic [SRC_IDX_W-1:0] idx,
                                                   input logic [SRC_IDX_W-1:0] cur);
`ifdef MGR_ARB_SRC0_PRIO_EN
    if (idx == '0) begin
      return cur;
    end
`endif
    if (cur == idx) begin
      return next_idx(idx);
    end
    return next_idx(idx);
  endfunction

  // Idle-state winner: first valid source at or after rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_IDX_W + 1)'(k);
      if (cand >= (SRC_IDX_W + 1)'(N_SRC)) begin
        cand = cand - (SRC_IDX_W + 1)'(N_SRC);
      end
      if (!sel_found && src_TVALID[cand[SRC_IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[SRC_IDX_W-1:0];
      end
    end
`ifdef MGR_ARB_SRC0_PRIO_EN
    if (src_TVALID[0]) begin
      sel_found = 1'b1;
      sel_idx   = '0;
    end
`endif
  end

  always_comb begin
    can_take = !out_valid_q || stream_out_TREADY;
    acc_idx  = (state_q == ARB_LOCK) ? grant_q : sel_idx;
    ready    = '0;
    if (!clk_ctrl_rst_high && can_take && ((state_q == ARB_LOCK) || sel_found)) begin
      ready[acc_idx] = 1'b1;
    end
    accept = src_TVALID[acc_idx] && ready[acc_idx];
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    // Drain and reload may coincide; a new beat always overrides the drain.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = src_TDATA[32*acc_idx +: 32];
      out_keep_d  = src_TKEEP[4*acc_idx +: 4];
      out_last_d  = src_TLAST[acc_idx];
    end else if (stream_out_TREADY) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          grant_d = sel_idx;
          if (src_TLAST[sel_idx]) begin
            rr_ptr_d = adv_ptr(sel_idx, rr_ptr_q);
          end else begin
            state_d = ARB_LOCK;
            busy_d  = 1'b1;
          end
        end
      end
      ARB_LOCK: begin
        if (accept && src_TLAST[grant_q]) begin
          state_d  = ARB_IDLE;
          busy_d   = 1'b0;
          rr_ptr_d = adv_ptr(grant_q, rr_ptr_q);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst_high) begin
    if (clk_ctrl_rst_high) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign src_TREADY        = ready;
  assign stream_out_TVALID = out_valid_q;
  assign stream_out_TDATA  = out_data_q;
  assign stream_out_TKEEP  = out_keep_q;
  assign stream_out_TLAST  = out_last_q;
  assign arb_busy          = busy_q;
  assign arb_grant         = grant_q;

endmodule

// File: tb/tb_mem_mgr_noc_out_arbiter.sv
// Scoreboard bench for mem_mgr_noc_out_arbiter: per-source beat queues feed the DUT, expected
// output beats are queued in arbitration order and popped as the output stream hands them off.
module tb_mem_mgr_noc_out_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic         clk;
  logic         rst;
  logic [3:0]   src_TVALID;
  logic [127:0] src_TDATA;
  logic [15:0]  src_TKEEP;
  logic [3:0]   src_TLAST;
  logic [3:0]   src_TREADY;
  logic         stream_out_TVALID;
  logic [31:0]  stream_out_TDATA;
  logic [3:0]   stream_out_TKEEP;
  logic         stream_out_TLAST;
  logic         stream_out_TREADY;
  logic         arb_busy;
  logic [1:0]   arb_grant;

  beat_t srcq [4][$];
  beat_t exp_q[$];
  logic  [3:0] hold;
  int    acc_cnt [4];
  logic  out_ready;
  int    n_cmp;
  int    n_err;

  mem_mgr_noc_out_arbiter #(.N_SRC(4), .SRC_IDX_W(2)) dut (
    .clk_ctrl          (clk),
    .clk_ctrl_rst_high (rst),
    .src_TVALID        (src_TVALID),
    .src_TDATA         (src_TDATA),
    .src_TKEEP         (src_TKEEP),
    .src_TLAST         (src_TLAST),
    .src_TREADY        (src_TREADY),
    .stream_out_TVALID (stream_out_TVALID),
    .stream_out_TDATA  (stream_out_TDATA),
    .stream_out_TKEEP  (stream_out_TKEEP),
    .stream_out_TLAST  (stream_out_TLAST),
    .stream_out_TREADY (stream_out_TREADY),
    .arb_busy          (arb_busy),
    .arb_grant         (arb_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    return b;
  endfunction

  function automatic beat_t got_beat();
    return mk(stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST);
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() > 0 && !hold[i]) begin
        src_TVALID[i]        = 1'b1;
        src_TDATA[32*i +: 32] = srcq[i][0].data;
        src_TKEEP[4*i +: 4]   = srcq[i][0].keep;
        src_TLAST[i]         = srcq[i][0].last;
      end else begin
        src_TVALID[i]        = 1'b0;
        src_TDATA[32*i +: 32] = '0;
        src_TKEEP[4*i +: 4]   = '0;
        src_TLAST[i]         = 1'b0;
      end
    end
    stream_out_TREADY = out_ready;
  endtask

  // Called between negedge and posedge: records handshakes, advances one cycle, re-drives.
  task automatic tick();
    logic [3:0] acc;
    #1;
    acc = src_TVALID & src_TREADY;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        void'(srcq[i].pop_front());
        acc_cnt[i]++;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      srcq[i].delete();
      acc_cnt[i] = 0;
    end
    exp_q.delete();
    hold      = '0;
    out_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hold = '0;
    out_ready = 1'b1;
    srcq[0].push_back(mk(32'h5555_0000, 4'hF, 1'b1));
    drive();
    @(negedge clk);
    n_cmp++;
    if ({stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST} !== 38'd0) begin
      n_err++;
      $display("[TB] FAIL rst_out: got v=%b d=%h k=%h l=%b, required all 0",
               stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST);
    end
    n_cmp++;
    if (src_TREADY !== 4'b0) begin
      n_err++;
      $display("[TB] FAIL rst_ready: got %b, required 0000", src_TREADY);
    end
    n_cmp++;
    if (arb_busy !== 1'b0 || arb_grant !== 2'd0) begin
      n_err++;
      $display("[TB] FAIL rst_arb: got busy=%b grant=%0d, required 0/0", arb_busy, arb_grant);
    end
    srcq[0].delete();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stream_out_TVALID !== 1'b0 || src_TREADY !== 4'b0) begin
      n_err++;
      $display("[TB] FAIL rst_idle: got v=%b ready=%b, required 0/0000", stream_out_TVALID, src_TREADY);
    end
  endtask

  task automatic test_single_packet();
    beat_t e;
    int    seen;
    do_reset();
    srcq[0].push_back(mk(32'h1A00_0001, 4'hF, 1'b0));
    srcq[0].push_back(mk(32'hDEAD_BEEF, 4'hF, 1'b0));
    srcq[0].push_back(mk(32'h0000_0042, 4'h3, 1'b1));
    for (int i = 0; i < 3; i++) exp_q.push_back(srcq[0][i]);
    drive();
    seen = 0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (stream_out_TVALID === 1'b1 && stream_out_TREADY === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL t1_beat: got unexpected %h, required none", got_beat());
        end else begin
          e = exp_q.pop_front();
          if (got_beat() !== e) begin
            n_err++;
            $display("[TB] FAIL t1_beat: got %h, required %h", got_beat(), e);
          end
        end
        n_cmp++;
        if (arb_busy !== (seen < 2) || arb_grant !== 2'd0) begin
          n_err++;
          $display("[TB] FAIL t1_arb: got busy=%b grant=%0d, required busy=%b grant=0",
                   arb_busy, arb_grant, (seen < 2));
        end
        seen++;
      end
      if (exp_q.size() > 0) tick();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL t1_drain: got %0d beats left, required 0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    beat_t e;
    do_reset();
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 4; i++) srcq[i].push_back(mk(32'h100 + i, 4'(4'hF - i), 1'b1));
`ifdef MGR_ARB_SRC0_PRIO_EN
    for (int r = 0; r < 8; r++) exp_q.push_back(mk(32'h100, 4'hF, 1'b1));
    for (int r = 0; r < 8; r++)
      for (int i = 1; i < 4; i++) exp_q.push_back(mk(32'h100 + i, 4'(4'hF - i), 1'b1));
`else
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'h100 + i, 4'(4'hF - i), 1'b1));
`endif
    drive();
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_cmp++;
        if (stream_out_TVALID !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL t2_nobubble: got TVALID=%b at cycle %0d, required 1", stream_out_TVALID, c);
        end
      end
      if (stream_out_TVALID === 1'b1 && stream_out_TREADY === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL t2_beat: got unexpected %h, required none", got_beat());
        end else begin
          e = exp_q.pop_front();
          if (got_beat() !== e) begin
            n_err++;
            $display("[TB] FAIL t2_beat: got %h, required %h", got_beat(), e);
          end
        end
      end
      if (exp_q.size() > 0) tick();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL t2_drain: got %0d beats left, required 0", exp_q.size());
    end
  endtask

  task automatic test_lock_and_bubble();
    beat_t e;
    logic  loaded2;
    int    bubble;
    do_reset();
    for (int b = 0; b < 4; b++) srcq[1].push_back(mk(32'hA100_0000 + b, 4'hF, (b == 3)));
    for (int b = 0; b < 4; b++) exp_q.push_back(srcq[1][b]);
    drive();
    loaded2 = 1'b0;
    bubble  = 0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (stream_out_TVALID === 1'b1 && stream_out_TREADY === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL t3_beat: got unexpected %h, required none", got_beat());
        end else begin
          e = exp_q.pop_front();
          if (got_beat() !== e) begin
            n_err++;
            $display("[TB] FAIL t3_beat: got %h, required %h", got_beat(), e);
          end
        end
      end
      if (loaded2 && acc_cnt[1] < 4) begin
        n_cmp++;
        if (src_TREADY[2] !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL t3_src2_blocked: got TREADY[2]=%b, required 0", src_TREADY[2]);
        end
        n_cmp++;
        if (arb_busy !== 1'b1 || arb_grant !== 2'd1) begin
          n_err++;
          $display("[TB] FAIL t3_hold: got busy=%b grant=%0d, required 1/1", arb_busy, arb_grant);
        end
      end
      if (exp_q.size() > 0) begin
        tick();
        if (acc_cnt[1] == 1 && !loaded2) begin
          loaded2 = 1'b1;
          srcq[2].push_back(mk(32'hB200_0000, 4'h1, 1'b1));
          exp_q.push_back(mk(32'hB200_0000, 4'h1, 1'b1));
        end
        hold[1] = (acc_cnt[1] == 2 && bubble < 5);
        if (hold[1]) bubble++;
        drive();
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || arb_grant !== 2'd2) begin
      n_err++;
      $display("[TB] FAIL t3_drain: got %0d left grant=%0d, required 0 left grant=2", exp_q.size(), arb_grant);
    end
  endtask

  task automatic test_backpressure();
    beat_t e;
    beat_t prev;
    logic  stalled;
    int    pat [4] = '{1, 0, 0, 1};
    do_reset();
    for (int b = 0; b < 4; b++) srcq[2].push_back(mk(32'hC0DE_0000 + 32'(b * 17), 4'(b + 1), (b == 3)));
    for (int b = 0; b < 4; b++) exp_q.push_back(srcq[2][b]);
    drive();
    stalled = 1'b0;
    prev    = '0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (stalled) begin
        n_cmp++;
        if (stream_out_TVALID !== 1'b1 || got_beat() !== prev) begin
          n_err++;
          $display("[TB] FAIL t4_stable: got v=%b %h, required v=1 %h", stream_out_TVALID, got_beat(), prev);
        end
      end
      stalled = (stream_out_TVALID === 1'b1 && stream_out_TREADY === 1'b0);
      prev    = got_beat();
      if (stalled) begin
        n_cmp++;
        if (src_TREADY !== 4'b0) begin
          n_err++;
          $display("[TB] FAIL t4_stall_ready: got %b, required 0000", src_TREADY);
        end
      end
      if (stream_out_TVALID === 1'b1 && stream_out_TREADY === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL t4_beat: got unexpected %h, required none", got_beat());
        end else begin
          e = exp_q.pop_front();
          if (got_beat() !== e) begin
            n_err++;
            $display("[TB] FAIL t4_beat: got %h, required %h", got_beat(), e);
          end
        end
      end
      if (exp_q.size() > 0) begin
        out_ready = pat[c % 4][0];
        tick();
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL t4_drain: got %0d beats left, required 0", exp_q.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    beat_t e;
    do_reset();
    for (int b = 0; b < 4; b++) srcq[3].push_back(mk(32'hD300_0000 + b, 4'hF, (b == 3)));
    exp_q.push_back(srcq[3][0]);
    exp_q.push_back(srcq[3][1]);
    drive();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stream_out_TVALID === 1'b1 && stream_out_TREADY === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL t5_beat: got unexpected %h, required none", got_beat());
        end else begin
          e = exp_q.pop_front();
          if (got_beat() !== e) begin
            n_err++;
            $display("[TB] FAIL t5_beat: got %h, required %h", got_beat(), e);
          end
        end
      end
      if (acc_cnt[3] >= 2 && exp_q.size() == 0) break;
      tick();
    end
    rst = 1'b1;
    srcq[3].delete();
    drive();
    #1;
    n_cmp++;
    if ({stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST} !== 38'd0 ||
        arb_grant !== 2'd0 || arb_busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL t5_rst: got v=%b d=%h grant=%0d busy=%b, required all 0",
               stream_out_TVALID, stream_out_TDATA, arb_grant, arb_busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
    for (int b = 0; b < 2; b++) srcq[2].push_back(mk(32'hE200_0000 + b, 4'hC, (b == 1)));
    for (int b = 0; b < 2; b++) exp_q.push_back(srcq[2][b]);
    drive();
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (stream_out_TVALID === 1'b1 && stream_out_TREADY === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL t5_after: got unexpected %h, required none", got_beat());
        end else begin
          e = exp_q.pop_front();
          if (got_beat() !== e) begin
            n_err++;
            $display("[TB] FAIL t5_after: got %h, required %h", got_beat(), e);
          end
        end
      end
      if (exp_q.size() > 0) tick();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL t5_drain: got %0d beats left, required 0", exp_q.size());
    end
  endtask

  task automatic test_src0_priority();
    beat_t e;
    logic  first;
    do_reset();
    srcq[0].push_back(mk(32'h600, 4'hF, 1'b1));
    exp_q.push_back(mk(32'h600, 4'hF, 1'b1));
    drive();
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (stream_out_TVALID === 1'b1 && stream_out_TREADY === 1'b1) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (got_beat() !== e) begin
          n_err++;
          $display("[TB] FAIL t6_warm: got %h, required %h", got_beat(), e);
        end
      end
      if (exp_q.size() > 0) tick();
    end
    tick();
    srcq[0].push_back(mk(32'h610, 4'hF, 1'b1));
    srcq[1].push_back(mk(32'h611, 4'hF, 1'b1));
`ifdef MGR_ARB_SRC0_PRIO_EN
    exp_q.push_back(mk(32'h610, 4'hF, 1'b1));
    exp_q.push_back(mk(32'h611, 4'hF, 1'b1));
`else
    exp_q.push_back(mk(32'h611, 4'hF, 1'b1));
    exp_q.push_back(mk(32'h610, 4'hF, 1'b1));
`endif
    drive();
    first = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (stream_out_TVALID === 1'b1 && stream_out_TREADY === 1'b1) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (got_beat() !== e) begin
          n_err++;
          $display("[TB] FAIL t6_order: got %h, required %h", got_beat(), e);
        end
        if (first) begin
          n_cmp++;
          if (arb_grant !== e.data[1:0]) begin
            n_err++;
            $display("[TB] FAIL t6_grant: got %0d, required %0d", arb_grant, e.data[1:0]);
          end
          first = 1'b0;
        end
      end
      if (exp_q.size() > 0) tick();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL t6_drain: got %0d beats left, required 0", exp_q.size());
    end
  endtask

  initial begin
    n_cmp             = 0;
    n_err             = 0;
    rst               = 1'b1;
    hold              = '0;
    out_ready         = 1'b1;
    src_TVALID        = '0;
    src_TDATA         = '0;
    src_TKEEP         = '0;
    src_TLAST         = '0;
    stream_out_TREADY = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_lock_and_bubble();
    test_backpressure();
    test_reset_mid_packet();
    test_src0_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
